// File: rtl/pcie_tlp_demux_core_pkg.sv
// Shared definitions for the TLP demultiplexer: fixed sideband field widths
// and the frame-tracking state encoding.
package pcie_tlp_demux_core_pkg;

  localparam int BAR_ID_WIDTH   = 3;
  localparam int FUNC_NUM_WIDTH = 8;
  localparam int ERROR_WIDTH    = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_e;

  // Bytes carried by one beat of the given payload width.
  function automatic int beat_bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/pcie_tlp_demux_fifo.sv
// Per-port output buffer carrying a packed TLP beat. ENABLE=1 gives a
// first-word-fall-through FIFO with registered fill-level flags; ENABLE=0
// collapses to a single register stage with both flags tied low.
module pcie_tlp_demux_fifo
  import pcie_tlp_demux_core_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 64,
  parameter int BEAT_BYTES = 32,
  parameter int WATERMARK  = 1024,
  parameter bit ENABLE     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_beat,
  input  logic             push,
  output logic             space,
  output logic [WIDTH-1:0] out_beat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             half_full,
  output logic             watermark
);

  if (ENABLE) begin : g_fifo
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             pop;

    assign pop        = out_valid & out_ready;
    assign count_next = count + CW'(push) - CW'(pop);
    assign out_valid  = (count != '0);
    assign space      = (count != CW'(DEPTH));
    assign out_beat   = mem[rd_ptr];

    // Pointers, occupancy and fill-level flags; flags track the occupancy
    // that this edge produces so they line up with the count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        half_full <= 1'b0;
        watermark <= 1'b0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        count     <= count_next;
        half_full <= (int'(count_next) * BEAT_BYTES) >= (DEPTH * BEAT_BYTES / 2);
        watermark <= (int'(count_next) * BEAT_BYTES) >= WATERMARK;
      end
    end

    // Beat storage write.
    // NOTE: storage is not reset; the pointers and count alone define which
    // entries are live, and leaving the array out of reset lets it map to RAM.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_beat;
    end
  end else begin : g_reg
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    assign space     = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_beat  = data_q;
    assign half_full = 1'b0;
    assign watermark = 1'b0;

    // Occupancy of the single stage: load on push, empty once taken.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)            valid_q <= 1'b0;
      else if (push)      valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;
    end

    // Payload capture; contents are don't-care while the stage is empty.
    always_ff @(posedge clk) begin
      if (push) data_q <= in_beat;
    end
  end

endmodule

// File: rtl/pcie_tlp_demux_core.sv
// Routes whole TLPs from a single-segment input stream to one of PORTS
// buffered outputs, or drops them, based on an external decoder's verdict
// taken on the SOP beat and held until EOP.
module pcie_tlp_demux_core
  import pcie_tlp_demux_core_pkg::*;
#(
  parameter int PORTS             = 2,
  parameter int TLP_DATA_WIDTH    = 256,
  parameter int TLP_STRB_WIDTH    = TLP_DATA_WIDTH / 32,
  parameter int TLP_HDR_WIDTH     = 128,
  parameter int SEQ_NUM_WIDTH     = 6,
  parameter int IN_TLP_SEG_COUNT  = 1,
  parameter int OUT_TLP_SEG_COUNT = 1,
  parameter bit FIFO_ENABLE       = 1'b1,
  parameter int FIFO_DEPTH        = 2048,
  parameter int FIFO_WATERMARK    = FIFO_DEPTH / 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [TLP_DATA_WIDTH-1:0]           in_tlp_data,
  input  logic [TLP_STRB_WIDTH-1:0]           in_tlp_strb,
  input  logic [TLP_HDR_WIDTH-1:0]            in_tlp_hdr,
  input  logic [SEQ_NUM_WIDTH-1:0]            in_tlp_seq,
  input  logic [BAR_ID_WIDTH-1:0]             in_tlp_bar_id,
  input  logic [FUNC_NUM_WIDTH-1:0]           in_tlp_func_num,
  input  logic [ERROR_WIDTH-1:0]              in_tlp_error,
  input  logic                                in_tlp_valid,
  input  logic                                in_tlp_sop,
  input  logic                                in_tlp_eop,
  output logic                                in_tlp_ready,
  output logic [PORTS*TLP_DATA_WIDTH-1:0]     out_tlp_data,
  output logic [PORTS*TLP_STRB_WIDTH-1:0]     out_tlp_strb,
  output logic [PORTS*TLP_HDR_WIDTH-1:0]      out_tlp_hdr,
  output logic [PORTS*SEQ_NUM_WIDTH-1:0]      out_tlp_seq,
  output logic [PORTS*BAR_ID_WIDTH-1:0]       out_tlp_bar_id,
  output logic [PORTS*FUNC_NUM_WIDTH-1:0]     out_tlp_func_num,
  output logic [PORTS*ERROR_WIDTH-1:0]        out_tlp_error,
  output logic [PORTS-1:0]                    out_tlp_valid,
  output logic [PORTS-1:0]                    out_tlp_sop,
  output logic [PORTS-1:0]                    out_tlp_eop,
  input  logic [PORTS-1:0]                    out_tlp_ready,
  output logic [TLP_HDR_WIDTH-1:0]            match_tlp_hdr,
  output logic [BAR_ID_WIDTH-1:0]             match_tlp_bar_id,
  output logic [FUNC_NUM_WIDTH-1:0]           match_tlp_func_num,
  input  logic                                enable,
  input  logic                                drop,
  input  logic [PORTS-1:0]                    select,
  output logic [PORTS-1:0]                    fifo_half_full,
  output logic [PORTS-1:0]                    fifo_watermark
);

  localparam int BEAT_W = TLP_DATA_WIDTH + TLP_STRB_WIDTH + TLP_HDR_WIDTH + SEQ_NUM_WIDTH
                        + BAR_ID_WIDTH + FUNC_NUM_WIDTH + ERROR_WIDTH + 2;
  localparam int FIFO_BEATS = FIFO_DEPTH * 8 / TLP_DATA_WIDTH;
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  if (IN_TLP_SEG_COUNT != 1 || OUT_TLP_SEG_COUNT != 1) begin : g_bad_seg_count
    $error("pcie_tlp_demux_core supports only single-segment streams");
  end

  frame_state_e     state_q, state_d;
  logic             discard_q;
  logic [PW-1:0]    port_q;
  logic [PW-1:0]    sel_port;
  logic             dec_discard;
  logic             beat_discard;
  logic [PW-1:0]    beat_port;
  logic             ready_ok;
  logic             accept;
  logic [PORTS-1:0] space;
  logic [PORTS-1:0] push;
  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] out_beat [PORTS];

  assign match_tlp_hdr      = in_tlp_hdr;
  assign match_tlp_bar_id   = in_tlp_bar_id;
  assign match_tlp_func_num = in_tlp_func_num;

  assign in_beat = {in_tlp_data, in_tlp_strb, in_tlp_hdr, in_tlp_seq, in_tlp_bar_id,
                    in_tlp_func_num, in_tlp_error, in_tlp_sop, in_tlp_eop};

  assign dec_discard  = drop | ~(|select);
  assign in_tlp_ready = ready_ok & ~rst;
  assign accept       = in_tlp_valid & in_tlp_ready;

  // Lowest set select bit wins; scanning downward lets the last hit stand.
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // updated value; clocked blocks use '<=' so all registers update together.
  always_comb begin
    sel_port = '0;
    for (int p = PORTS - 1; p >= 0; p--) begin
      if (select[p]) sel_port = PW'(p);
    end
  end

  // Frame FSM next state, acceptance and per-beat routing decision.
  always_comb begin
    state_d      = state_q;
    ready_ok     = 1'b0;
    beat_discard = 1'b1;
    beat_port    = port_q;
    case (state_q)
      ST_IDLE: begin
        if (in_tlp_sop) begin
          beat_discard = dec_discard;
          beat_port    = sel_port;
          ready_ok     = enable & (dec_discard | space[sel_port]);
          if (in_tlp_valid && ready_ok && !in_tlp_eop) state_d = ST_FRAME;
        end else begin
          ready_ok = 1'b1;
        end
      end
      ST_FRAME: begin
        beat_discard = discard_q;
        beat_port    = port_q;
        ready_ok     = discard_q | space[port_q];
        if (in_tlp_valid && ready_ok && in_tlp_eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and the decision held for the remainder of the packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      discard_q <= 1'b1;
      port_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && accept && in_tlp_sop) begin
        discard_q <= beat_discard;
        port_q    <= beat_port;
      end
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    assign push[p] = accept & ~beat_discard & (beat_port == PW'(p));

    pcie_tlp_demux_fifo #(
      .WIDTH      (BEAT_W),
      .DEPTH      (FIFO_BEATS),
      .BEAT_BYTES (beat_bytes(TLP_DATA_WIDTH)),
      .WATERMARK  (FIFO_WATERMARK),
      .ENABLE     (FIFO_ENABLE)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_beat   (in_beat),
      .push      (push[p]),
      .space     (space[p]),
      .out_beat  (out_beat[p]),
      .out_valid (out_tlp_valid[p]),
      .out_ready (out_tlp_ready[p]),
      .half_full (fifo_half_full[p]),
      .watermark (fifo_watermark[p])
    );

    assign {out_tlp_data[p*TLP_DATA_WIDTH +: TLP_DATA_WIDTH],
            out_tlp_strb[p*TLP_STRB_WIDTH +: TLP_STRB_WIDTH],
            out_tlp_hdr[p*TLP_HDR_WIDTH +: TLP_HDR_WIDTH],
            out_tlp_seq[p*SEQ_NUM_WIDTH +: SEQ_NUM_WIDTH],
            out_tlp_bar_id[p*BAR_ID_WIDTH +: BAR_ID_WIDTH],
            out_tlp_func_num[p*FUNC_NUM_WIDTH +: FUNC_NUM_WIDTH],
            out_tlp_error[p*ERROR_WIDTH +: ERROR_WIDTH],
            out_tlp_sop[p],
            out_tlp_eop[p]} = out_beat[p];
  end

endmodule

// File: tb/tb_pcie_tlp_demux_core.sv
// Scoreboard bench for pcie_tlp_demux_core at default parameters.
module tb_pcie_tlp_demux_core;

  typedef struct packed {
    logic [255:0] data;
    logic [7:0]   strb;
    logic [127:0] hdr;
    logic [5:0]   seq;
    logic [2:0]   bar;
    logic [7:0]   func;
    logic [3:0]   err;
    logic         sop;
    logic         eop;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] in_tlp_data = '0;
  logic [7:0]   in_tlp_strb = '0;
  logic [127:0] in_tlp_hdr = '0;
  logic [5:0]   in_tlp_seq = '0;
  logic [2:0]   in_tlp_bar_id = '0;
  logic [7:0]   in_tlp_func_num = '0;
  logic [3:0]   in_tlp_error = '0;
  logic         in_tlp_valid = 1'b0;
  logic         in_tlp_sop = 1'b0;
  logic         in_tlp_eop = 1'b0;
  logic         in_tlp_ready;
  logic [511:0] out_tlp_data;
  logic [15:0]  out_tlp_strb;
  logic [255:0] out_tlp_hdr;
  logic [11:0]  out_tlp_seq;
  logic [5:0]   out_tlp_bar_id;
  logic [15:0]  out_tlp_func_num;
  logic [7:0]   out_tlp_error;
  logic [1:0]   out_tlp_valid;
  logic [1:0]   out_tlp_sop;
  logic [1:0]   out_tlp_eop;
  logic [1:0]   out_tlp_ready = 2'b11;
  logic [127:0] match_tlp_hdr;
  logic [2:0]   match_tlp_bar_id;
  logic [7:0]   match_tlp_func_num;
  logic         enable = 1'b1;
  logic         drop = 1'b0;
  logic [1:0]   select = 2'b01;
  logic [1:0]   fifo_half_full;
  logic [1:0]   fifo_watermark;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t exp_q [2][$];

  pcie_tlp_demux_core dut (
    .clk                (clk),
    .rst                (rst),
    .in_tlp_data        (in_tlp_data),
    .in_tlp_strb        (in_tlp_strb),
    .in_tlp_hdr         (in_tlp_hdr),
    .in_tlp_seq         (in_tlp_seq),
    .in_tlp_bar_id      (in_tlp_bar_id),
    .in_tlp_func_num    (in_tlp_func_num),
    .in_tlp_error       (in_tlp_error),
    .in_tlp_valid       (in_tlp_valid),
    .in_tlp_sop         (in_tlp_sop),
    .in_tlp_eop         (in_tlp_eop),
    .in_tlp_ready       (in_tlp_ready),
    .out_tlp_data       (out_tlp_data),
    .out_tlp_strb       (out_tlp_strb),
    .out_tlp_hdr        (out_tlp_hdr),
    .out_tlp_seq        (out_tlp_seq),
    .out_tlp_bar_id     (out_tlp_bar_id),
    .out_tlp_func_num   (out_tlp_func_num),
    .out_tlp_error      (out_tlp_error),
    .out_tlp_valid      (out_tlp_valid),
    .out_tlp_sop        (out_tlp_sop),
    .out_tlp_eop        (out_tlp_eop),
    .out_tlp_ready      (out_tlp_ready),
    .match_tlp_hdr      (match_tlp_hdr),
    .match_tlp_bar_id   (match_tlp_bar_id),
    .match_tlp_func_num (match_tlp_func_num),
    .enable             (enable),
    .drop               (drop),
    .select             (select),
    .fifo_half_full     (fifo_half_full),
    .fifo_watermark     (fifo_watermark)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: idle ports must stay invalid, taken beats must match the queue head.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        if (exp_q[p].size() == 0) begin
          check($sformatf("p%0d_idle_valid", p), 256'(out_tlp_valid[p]), 256'(0));
        end else if (out_tlp_valid[p] && out_tlp_ready[p]) begin
          e = exp_q[p].pop_front();
          check($sformatf("p%0d_data", p), out_tlp_data[p*256 +: 256], e.data);
          check($sformatf("p%0d_hdr", p), 256'(out_tlp_hdr[p*128 +: 128]), 256'(e.hdr));
          check($sformatf("p%0d_fields", p),
                256'({out_tlp_strb[p*8 +: 8], out_tlp_seq[p*6 +: 6], out_tlp_bar_id[p*3 +: 3],
                      out_tlp_func_num[p*8 +: 8], out_tlp_error[p*4 +: 4],
                      out_tlp_sop[p], out_tlp_eop[p]}),
                256'({e.strb, e.seq, e.bar, e.func, e.err, e.sop, e.eop}));
        end
      end
    end
  end

  task automatic present(input bit sop, input bit eop, input logic [127:0] hdr, input logic [2:0] bar);
    in_tlp_data     = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
    in_tlp_strb     = 8'($urandom());
    in_tlp_hdr      = hdr;
    in_tlp_seq      = 6'($urandom());
    in_tlp_bar_id   = bar;
    in_tlp_func_num = 8'($urandom());
    in_tlp_error    = 4'($urandom());
    in_tlp_sop      = sop;
    in_tlp_eop      = eop;
    in_tlp_valid    = 1'b1;
  endtask

  // Drive one beat until accepted; port < 0 means the beat must be discarded.
  task automatic send_beat(input bit sop, input bit eop, input logic [127:0] hdr,
                           input logic [2:0] bar, input int port);
    bit    got = 1'b0;
    beat_t b;
    present(sop, eop, hdr, bar);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("match_bar", 256'(match_tlp_bar_id), 256'(bar));
        check("match_hdr", 256'(match_tlp_hdr), 256'(hdr));
        if (port < 0) check("discard_ready", 256'(in_tlp_ready), 256'(1));
      end
      if (in_tlp_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 256'(in_tlp_ready), 256'(1));
    else if (port >= 0) begin
      b = '{in_tlp_data, in_tlp_strb, in_tlp_hdr, in_tlp_seq, in_tlp_bar_id,
            in_tlp_func_num, in_tlp_error, in_tlp_sop, in_tlp_eop};
      exp_q[port].push_back(b);
    end
    @(posedge clk);
    #1;
    in_tlp_valid = 1'b0;
  endtask

  task automatic send_pkt(input int nbeats, input logic [127:0] hdr, input logic [2:0] bar,
                          input int port);
    for (int i = 0; i < nbeats; i++) send_beat(i == 0, i == nbeats - 1, hdr, bar, port);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 500 && (exp_q[0].size() + exp_q[1].size()) != 0; c++) @(posedge clk);
    #1;
    check(tag, 256'(exp_q[0].size() + exp_q[1].size()), 256'(0));
  endtask

  initial begin
    // Reset state, with a valid SOP offered during reset.
    present(1'b1, 1'b0, 128'h1, 3'd0);
    @(negedge clk);
    check("rst_ready", 256'(in_tlp_ready), 256'(0));
    check("rst_valid", 256'(out_tlp_valid), 256'(0));
    check("rst_status", 256'({fifo_half_full, fifo_watermark}), 256'(0));
    in_tlp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three-beat packet to port 1.
    select = 2'b10;
    send_pkt(3, {16{8'hAA}}, 3'd1, 1);
    drain("t1_drain");

    // Dropped by verdict, then by empty select.
    select = 2'b01;
    drop   = 1'b1;
    send_pkt(4, 128'h4444, 3'd2, -1);
    drop   = 1'b0;
    select = 2'b00;
    send_pkt(4, 128'h5555, 3'd3, -1);
    drain("t2_drain");

    // Select changes after the SOP beat; packet stays on port 0.
    select = 2'b01;
    send_beat(1'b1, 1'b0, 128'h6666, 3'd4, 0);
    select = 2'b10;
    send_beat(1'b0, 1'b0, 128'h6666, 3'd4, 0);
    send_beat(1'b0, 1'b1, 128'h6666, 3'd4, 0);
    drain("t3_drain");

    // Enable dropped mid-packet: packet completes, next SOP stalls.
    select = 2'b01;
    send_beat(1'b1, 1'b0, 128'h7777, 3'd5, 0);
    enable = 1'b0;
    send_beat(1'b0, 1'b0, 128'h7777, 3'd5, 0);
    send_beat(1'b0, 1'b1, 128'h7777, 3'd5, 0);
    present(1'b1, 1'b1, 128'h8888, 3'd6);
    repeat (3) @(negedge clk);
    check("en0_stall", 256'(in_tlp_ready), 256'(0));
    @(posedge clk);
    #1;
    enable = 1'b1;
    send_beat(1'b1, 1'b1, 128'h8888, 3'd6, 0);
    drain("t4_drain");

    // Fill port 0 while it is backpressured; port 1 still flows.
    out_tlp_ready = 2'b10;
    select = 2'b01;
    for (int i = 0; i < 64; i++) begin
      send_beat(i == 0, i == 63, 128'h9999, 3'd7, 0);
      if (i == 30) check("hf_at31", 256'({fifo_half_full[0], fifo_watermark[0]}), 256'(0));
      if (i == 31) check("hf_at32", 256'({fifo_half_full[0], fifo_watermark[0]}), 256'(3));
    end
    select = 2'b10;
    send_pkt(2, 128'hBBBB, 3'd1, 1);
    select = 2'b01;
    present(1'b1, 1'b1, 128'hCCCC, 3'd2);
    repeat (2) @(negedge clk);
    check("full_stall", 256'(in_tlp_ready), 256'(0));
    check("full_hf", 256'(fifo_half_full[0]), 256'(1));
    @(posedge clk);
    #1;
    out_tlp_ready = 2'b11;
    send_beat(1'b1, 1'b1, 128'hCCCC, 3'd2, 0);
    drain("t5_drain");
    check("t5_hf_clear", 256'({fifo_half_full, fifo_watermark}), 256'(0));

    // Reset mid-packet with beats parked in port 1.
    out_tlp_ready = 2'b01;
    select = 2'b10;
    send_beat(1'b1, 1'b0, 128'hDDDD, 3'd3, 1);
    send_beat(1'b0, 1'b0, 128'hDDDD, 3'd3, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 256'(out_tlp_valid), 256'(0));
    check("mid_rst_ready", 256'(in_tlp_ready), 256'(0));
    check("mid_rst_status", 256'({fifo_half_full, fifo_watermark}), 256'(0));
    exp_q[0].delete();
    exp_q[1].delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_tlp_ready = 2'b11;
    send_beat(1'b0, 1'b1, 128'hEEEE, 3'd4, -1);
    select = 2'b01;
    send_pkt(2, 128'hFFFF, 3'd5, 0);
    drain("t6_drain");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
